// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and helpers for the AXI read/write arbiters
//
// Purpose : arbiter FSM state encoding, index-width helper, default watchdog limit.
// Ports   : none (package).
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   localparam int ARB_TIMEOUT_DEFAULT = 1024;

   // At least one bit, even for the degenerate single-bit case.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//
// Purpose : selects the first asserted req bit scanning ptr+1, ptr+2, ... modulo N.
// Ports   : req    in  N      request vector
//           ptr    in  IDX_W  last winner; lowest priority this round
//           onehot out N      one-hot winner (zero when no request)
//           idx    out IDX_W  encoded winner (zero when no request)
//           any    out 1      at least one request present
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic found;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      any    = |req;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (!found && req[c]) begin
            found     = 1'b1;
            onehot[c] = 1'b1;
            idx       = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/axi_arbiter_rd_rr.sv
// rtl/axi_arbiter_rd_rr.sv - round-robin N-master AXI read-channel (AR+R) arbiter
//
// Purpose : grants one master the shared AR/R path from AR issue until the RLAST
//           handshake, re-arbitrating back-to-back with round-robin fairness.
// Option  : AXI_ARB_RD_WATCHDOG_EN adds a stall watchdog that releases a hung grant.
// Ports   : ACLK, ARESETn         clock, async active-low reset
//           m_arvalid, m_rready   per-master request / read-data ready
//           s_arready, s_rvalid,
//           s_rlast               slave-side handshake signals
//           rgrnt, rgrnt_idx      registered one-hot / encoded grant
//           busy                  a transaction owns the path (ADDR or DATA)
//           timeout_err           one-cycle watchdog expiry pulse
module axi_arbiter_rd_rr
   import axi_arb_pkg::*;
#(
   parameter int  NUM_MASTERS    = 4,
   parameter int  TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
   localparam int IDX_W          = idx_width(NUM_MASTERS)
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [NUM_MASTERS-1:0] m_arvalid,
   input  logic [NUM_MASTERS-1:0] m_rready,
   input  logic                   s_arready,
   input  logic                   s_rvalid,
   input  logic                   s_rlast,
   output logic [NUM_MASTERS-1:0] rgrnt,
   output logic [IDX_W-1:0]       rgrnt_idx,
   output logic                   busy,
   output logic                   timeout_err
);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] rgrnt_q, rgrnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   r_hs;
   logic                   final_beat;

   rr_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (m_arvalid),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign r_hs       = s_rvalid && m_rready[idx_q];
   assign final_beat = r_hs && s_rlast;

`ifdef AXI_ARB_RD_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      rgrnt_d = rgrnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
`ifdef AXI_ARB_RD_WATCHDOG_EN
      tmo_d   = 1'b0;
      cnt_d   = (state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;
      if (r_hs) cnt_d = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               rgrnt_d = pick_onehot;
               idx_d   = pick_idx;
               ptr_d   = pick_idx;
               state_d = ADDR;
            end
         end
         // A master dropping ARVALID here is a protocol violation; the grant is
         // simply held rather than re-arbitrated.
         ADDR: begin
            if (m_arvalid[idx_q] && s_arready) state_d = DATA;
         end
         DATA: begin
            if (final_beat) begin
               if (pick_any) begin
                  rgrnt_d = pick_onehot;
                  idx_d   = pick_idx;
                  ptr_d   = pick_idx;
                  state_d = ADDR;
               end else begin
                  rgrnt_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            rgrnt_d = '0;
            state_d = IDLE;
         end
      endcase
`ifdef AXI_ARB_RD_WATCHDOG_EN
      if (state_d != state_q && state_d != IDLE) cnt_d = '0;
      // Expiry only when nothing else moved this cycle; ptr keeps the hung
      // master so the next scan starts just past it.
      if (state_q != IDLE && state_d == state_q && !r_hs &&
          cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
         tmo_d   = 1'b1;
         rgrnt_d = '0;
         ptr_d   = idx_q;
         state_d = IDLE;
      end
`endif
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         rgrnt_q <= '0;
         idx_q   <= '0;
         ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         rgrnt_q <= rgrnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef AXI_ARB_RD_WATCHDOG_EN
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign rgrnt     = rgrnt_q;
   assign rgrnt_idx = idx_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_arbiter_rd_rr.sv
// tb/tb_axi_arbiter_rd_rr.sv - directed self-checking bench for axi_arbiter_rd_rr
module tb_axi_arbiter_rd_rr;

`ifdef AXI_ARB_RD_WATCHDOG_EN
   localparam int TB_TMO = 16;
`else
   localparam int TB_TMO = 1024;
`endif

   logic       ACLK = 1'b0;
   logic       ARESETn = 1'b0;
   logic [3:0] m_arvalid = '0;
   logic [3:0] m_rready = '0;
   logic       s_arready = 1'b0;
   logic       s_rvalid = 1'b0;
   logic       s_rlast = 1'b0;
   logic [3:0] rgrnt;
   logic [1:0] rgrnt_idx;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   axi_arbiter_rd_rr #(
      .NUM_MASTERS    (4),
      .TIMEOUT_CYCLES (TB_TMO)
   ) dut (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .m_arvalid   (m_arvalid),
      .m_rready    (m_rready),
      .s_arready   (s_arready),
      .s_rvalid    (s_rvalid),
      .s_rlast     (s_rlast),
      .rgrnt       (rgrnt),
      .rgrnt_idx   (rgrnt_idx),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick;
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset;
      ARESETn = 1'b0;
      m_arvalid = '0; m_rready = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
      tick();
      tick();
      ARESETn = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({rgrnt, rgrnt_idx, busy, timeout_err} !== 8'b0000_00_0_0) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", {rgrnt, rgrnt_idx, busy, timeout_err}, 8'b0);
      end
   endtask

   task automatic test_single;
      m_arvalid = 4'b0001;
      tick();
      checks++;
      if ({rgrnt, rgrnt_idx, busy} !== 7'b0001_00_1) begin
         errors++;
         $display("FAIL single_grant got=%b exp=%b", {rgrnt, rgrnt_idx, busy}, 7'b0001_00_1);
      end
      // ARVALID dropped by the granted master while others request: grant held.
      m_arvalid = 4'b1000; s_arready = 1'b1;
      tick();
      checks++;
      if ({rgrnt, busy} !== 5'b0001_1) begin
         errors++;
         $display("FAIL addr_drop_hold got=%b exp=%b", {rgrnt, busy}, 5'b0001_1);
      end
      m_arvalid = 4'b0001;
      tick();
      m_arvalid = '0; s_arready = 1'b0;
      s_rvalid = 1'b1; m_rready = 4'b0001;
      for (int b = 0; b < 3; b++) begin
         tick();
         checks++;
         if ({rgrnt, busy} !== 5'b0001_1) begin
            errors++;
            $display("FAIL single_beat%0d got=%b exp=%b", b, {rgrnt, busy}, 5'b0001_1);
         end
      end
      s_rlast = 1'b1;
      tick();
      checks++;
      if ({rgrnt, busy} !== 5'b0000_0) begin
         errors++;
         $display("FAIL single_last got=%b exp=%b", {rgrnt, busy}, 5'b0000_0);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_oh;
      logic [1:0] exp_idx;
      do_reset();
      m_arvalid = 4'b1111; m_rready = 4'b1111;
      s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
      // ADDR and DATA alternate each edge: grant sequence 0,0,1,1,2,2,3,3,0,0.
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_idx = 2'((k - 1) / 2);
         exp_oh  = 4'b0001 << exp_idx;
         checks++;
         if ({rgrnt, rgrnt_idx, busy} !== {exp_oh, exp_idx, 1'b1}) begin
            errors++;
            $display("FAIL b2b_cycle%0d got=%b exp=%b", k, {rgrnt, rgrnt_idx, busy}, {exp_oh, exp_idx, 1'b1});
         end
      end
      m_arvalid = '0;
      tick();
      checks++;
      if ({rgrnt, busy} !== 5'b0000_0) begin
         errors++;
         $display("FAIL b2b_drain got=%b exp=%b", {rgrnt, busy}, 5'b0000_0);
      end
      s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
   endtask

   task automatic test_stall;
      // {s_rvalid, m_rready[2], s_rlast}; none completes the burst.
      logic [2:0] pat [7];
      pat = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b101, 3'b011, 3'b000};
      do_reset();
      m_arvalid = 4'b0100;
      tick();
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      m_arvalid = 4'b0010;
      for (int p = 0; p < 7; p++) begin
         s_rvalid = pat[p][2];
         m_rready = pat[p][1] ? 4'b0100 : 4'b1011;
         s_rlast  = pat[p][0];
         tick();
         checks++;
         if ({rgrnt, rgrnt_idx, busy, timeout_err} !== 8'b0100_10_1_0) begin
            errors++;
            $display("FAIL stall_pat%0d got=%b exp=%b", p, {rgrnt, rgrnt_idx, busy, timeout_err}, 8'b0100_10_1_0);
         end
      end
      s_rvalid = 1'b1; m_rready = 4'b0100; s_rlast = 1'b1;
      tick();
      checks++;
      if ({rgrnt, rgrnt_idx, busy} !== 7'b0010_01_1) begin
         errors++;
         $display("FAIL stall_regrant got=%b exp=%b", {rgrnt, rgrnt_idx, busy}, 7'b0010_01_1);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b1;
      tick();
      m_arvalid = '0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 4'b0010;
      tick();
      checks++;
      if ({rgrnt, busy} !== 5'b0000_0) begin
         errors++;
         $display("FAIL stall_finish got=%b exp=%b", {rgrnt, busy}, 5'b0000_0);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
   endtask

   task automatic test_reset_mid;
      do_reset();
      m_arvalid = 4'b1000;
      tick();
      s_arready = 1'b1;
      tick();
      m_arvalid = '0; s_arready = 1'b0;
      checks++;
      if ({rgrnt, rgrnt_idx, busy} !== 7'b1000_11_1) begin
         errors++;
         $display("FAIL rstmid_pre got=%b exp=%b", {rgrnt, rgrnt_idx, busy}, 7'b1000_11_1);
      end
      #2;
      ARESETn = 1'b0;
      #1;
      checks++;
      if ({rgrnt, rgrnt_idx, busy} !== 7'b0000_00_0) begin
         errors++;
         $display("FAIL rstmid_async got=%b exp=%b", {rgrnt, rgrnt_idx, busy}, 7'b0000_00_0);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      m_arvalid = 4'b1111;
      tick();
      checks++;
      if ({rgrnt, rgrnt_idx, busy} !== 7'b0001_00_1) begin
         errors++;
         $display("FAIL rstmid_regrant got=%b exp=%b", {rgrnt, rgrnt_idx, busy}, 7'b0001_00_1);
      end
      m_arvalid = '0;
   endtask

`ifdef AXI_ARB_RD_WATCHDOG_EN
   task automatic test_watchdog;
      do_reset();
      m_arvalid = 4'b0110;
      tick();
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      // Counter is zero on DATA entry; expiry lands on the 16th edge.
      for (int c = 1; c <= 15; c++) begin
         tick();
         checks++;
         if ({rgrnt, busy, timeout_err} !== 6'b0010_1_0) begin
            errors++;
            $display("FAIL wdog_wait%0d got=%b exp=%b", c, {rgrnt, busy, timeout_err}, 6'b0010_1_0);
         end
      end
      tick();
      checks++;
      if ({rgrnt, busy, timeout_err} !== 6'b0000_0_1) begin
         errors++;
         $display("FAIL wdog_expire got=%b exp=%b", {rgrnt, busy, timeout_err}, 6'b0000_0_1);
      end
      tick();
      checks++;
      if ({rgrnt, rgrnt_idx, busy, timeout_err} !== 8'b0100_10_1_0) begin
         errors++;
         $display("FAIL wdog_next got=%b exp=%b", {rgrnt, rgrnt_idx, busy, timeout_err}, 8'b0100_10_1_0);
      end
      m_arvalid = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef AXI_ARB_RD_WATCHDOG_EN
      test_watchdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
